multi_arbiter_wr: RTL and testbench

MULTI_ARBITER_WR -- requirements
Module: multi_arbiter_wr

---
 rtl/multi_arbiter_wr_if.sv | 27 ++
 rtl/multi_arbiter_wr.sv | 103 ++++++++++
 tb/tb_multi_arbiter_wr.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_arbiter_wr_if.sv
// Token bus for multi_arbiter_wr: N input channels, a select channel, and the
// paired out/chose outputs with their stall returns.
interface multi_arbiter_wr_if #(
  parameter int F = 8,
  parameter int N = 4,
  parameter int S = $clog2(N)
) ();
  logic [N-1:0][F:0] in_data;
  logic [N-1:0]      in_back_stop;
  logic [S:0]        sel_data;
  logic              sel_back_stop;
  logic [F:0]        out_data;
  logic              out_down_stop;
  logic [S:0]        chose_data;
  logic              chose_down_stop;
  logic              err_bad_sel;

  modport slave (
    input  in_data, sel_data, out_down_stop, chose_down_stop,
    output in_back_stop, sel_back_stop, out_data, chose_data, err_bad_sel
  );

  modport master (
    output in_data, sel_data, out_down_stop, chose_down_stop,
    input  in_back_stop, sel_back_stop, out_data, chose_data, err_bad_sel
  );
endinterface

// File: rtl/multi_arbiter_wr.sv
// N-way token arbiter with a single registered output entry; grants are
// steered by a select token (MODE 0) or round-robin (MODE 1).
module multi_arbiter_wr #(
  parameter int F    = 8,
  parameter int N    = 4,
  parameter int S    = $clog2(N),
  parameter int MODE = 0
) (
  input logic               clk,
  input logic               reset,
  multi_arbiter_wr_if.slave bus
);

  logic           out_valid;
  logic [F-1:0]   out_payload;
  logic [S-1:0]   chose_idx;
  logic           err_q;
  logic [S-1:0]   rr_ptr;

  logic           sel_valid;
  logic [S-1:0]   sel_idx;
  logic           drain;
  logic           can_accept;
  logic           hit;
  logic           fire;
  logic           bad_sel;
  logic [S-1:0]   grant;
  logic [F-1:0]   grant_payload;

  assign sel_valid  = bus.sel_data[S];
  assign sel_idx    = bus.sel_data[S-1:0];
  assign drain      = out_valid && !bus.out_down_stop && !bus.chose_down_stop;
  assign can_accept = !reset && (!out_valid || drain);

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : arbitrate
    int idx;
    idx           = 0;
    hit           = 1'b0;
    grant         = '0;
    grant_payload = '0;
    bad_sel       = 1'b0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (sel_valid && int'(sel_idx) == i && bus.in_data[i][F]) begin
          hit           = 1'b1;
          grant         = S'(i);
          grant_payload = bus.in_data[i][F-1:0];
        end
      end
      bad_sel = can_accept && sel_valid && (int'(sel_idx) >= N);
    end else begin
      // Walk downward so the last hit kept is the nearest valid channel at or after rr_ptr.
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr) + k) % N;
        if (bus.in_data[idx][F]) begin
          hit           = 1'b1;
          grant         = S'(idx);
          grant_payload = bus.in_data[idx][F-1:0];
        end
      end
    end
    fire = can_accept && hit;
  end

  always_comb begin
    bus.in_back_stop = '1;
    for (int i = 0; i < N; i++) begin
      if (fire && grant == S'(i)) bus.in_back_stop[i] = 1'b0;
    end
  end

  assign bus.sel_back_stop = (MODE == 0) ? !(fire || bad_sel) : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      err_q     <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      err_q <= bad_sel;
      if (fire) begin
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (MODE == 1 && fire) rr_ptr <= S'((int'(grant) + 1) % N);
    end
  end

  // NOTE: payload and index registers carry no reset; out_valid qualifies them, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (fire) begin
      out_payload <= grant_payload;
      chose_idx   <= grant;
    end
  end

  assign bus.out_data    = {out_valid, out_payload};
  assign bus.chose_data  = {out_valid, chose_idx};
  assign bus.err_bad_sel = err_q;

endmodule

// File: tb/tb_multi_arbiter_wr.sv
// Scoreboard bench: three arbiters (MODE 0 N=4, MODE 1 N=4, MODE 0 N=3) share
// one stimulus stream and are checked against a rule-level reference model.
module tb_multi_arbiter_wr;

  typedef struct packed {
    logic [7:0] payload;
    logic [1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_arbiter_wr_if #(.F(8), .N(4)) bus0 ();
  multi_arbiter_wr_if #(.F(8), .N(4)) bus1 ();
  multi_arbiter_wr_if #(.F(8), .N(3)) bus2 ();

  multi_arbiter_wr #(.F(8), .N(4), .MODE(0)) u_m0 (.clk(clk), .reset(rst), .bus(bus0.slave));
  multi_arbiter_wr #(.F(8), .N(4), .MODE(1)) u_m1 (.clk(clk), .reset(rst), .bus(bus1.slave));
  multi_arbiter_wr #(.F(8), .N(3), .MODE(0)) u_n3 (.clk(clk), .reset(rst), .bus(bus2.slave));

  // Observed outputs gathered per DUT
  logic [3:0] ibs [3];
  logic       sbs [3];
  logic [8:0] od  [3];
  logic [2:0] cd  [3];
  logic       err [3];

  assign ibs[0] = bus0.in_back_stop;
  assign ibs[1] = bus1.in_back_stop;
  assign ibs[2] = {1'b1, bus2.in_back_stop};
  assign sbs[0] = bus0.sel_back_stop;
  assign sbs[1] = bus1.sel_back_stop;
  assign sbs[2] = bus2.sel_back_stop;
  assign od[0]  = bus0.out_data;
  assign od[1]  = bus1.out_data;
  assign od[2]  = bus2.out_data;
  assign cd[0]  = bus0.chose_data;
  assign cd[1]  = bus1.chose_data;
  assign cd[2]  = bus2.chose_data;
  assign err[0] = bus0.err_bad_sel;
  assign err[1] = bus1.err_bad_sel;
  assign err[2] = bus2.err_bad_sel;

  // Stimulus requested by the sequencer, and the copy actually applied
  logic [8:0] in_v [4];
  logic [2:0] sel_v;
  logic       ods_v, cds_v, rst_v;
  logic [8:0] a_in [4];
  logic [2:0] a_sel;
  logic       a_ods, a_cds, a_rst;

  // Reference model state
  bit   m_full [3];
  int   m_rr   [3];
  bit   m_err  [3];
  exp_t exp_q  [3][$];
  bit   armed = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    for (int d = 0; d < 3; d++) begin
      int   n, grant, idx;
      bit   mode, drain, can, fire, bad, found;
      logic [3:0] e_ibs;
      exp_t e;
      n     = (d == 2) ? 3 : 4;
      mode  = (d == 1);
      drain = m_full[d] && !a_ods && !a_cds;
      can   = !a_rst && (!m_full[d] || drain);
      fire  = 1'b0;
      bad   = 1'b0;
      found = 1'b0;
      grant = 0;
      if (!mode) begin
        if (a_sel[2] === 1'b1) begin
          idx = int'(a_sel[1:0]);
          if (idx >= n) bad = can;
          else if (a_in[idx][8] === 1'b1) begin
            fire  = can;
            grant = idx;
          end
        end
      end else begin
        for (int k = 0; k < n; k++) begin
          idx = (m_rr[d] + k) % n;
          if (!found && a_in[idx][8] === 1'b1) begin
            found = 1'b1;
            grant = idx;
          end
        end
        fire = can && found;
      end
      e_ibs = 4'hF;
      if (fire) e_ibs[grant] = 1'b0;
      check($sformatf("in_back_stop[dut%0d]", d), 32'(ibs[d]), 32'(e_ibs));
      check($sformatf("sel_back_stop[dut%0d]", d), 32'(sbs[d]), mode ? 32'd1 : 32'(!(fire || bad)));
      if (armed) begin
        check($sformatf("out_valid[dut%0d]", d), 32'(od[d][8]), 32'(m_full[d]));
        check($sformatf("err_bad_sel[dut%0d]", d), 32'(err[d]), 32'(m_err[d]));
      end
      if (a_rst) begin
        m_full[d] = 1'b0;
        m_rr[d]   = 0;
        m_err[d]  = 1'b0;
        exp_q[d].delete();
      end else begin
        m_err[d] = bad;
        if (fire) begin
          e = {a_in[grant][7:0], 2'(grant)};
          exp_q[d].push_back(e);
          m_full[d] = 1'b1;
          if (mode) m_rr[d] = (grant + 1) % n;
        end else if (drain) begin
          m_full[d] = 1'b0;
        end
      end
    end
    if (a_rst) armed = 1'b1;
  endtask

  // Apply stimulus after the falling edge, then evaluate the model just before the rising edge.
  task automatic tick();
    @(negedge clk);
    a_rst = rst_v;
    a_sel = sel_v;
    a_ods = ods_v;
    a_cds = cds_v;
    rst   = rst_v;
    for (int i = 0; i < 4; i++) begin
      a_in[i]          = in_v[i];
      bus0.in_data[i]  = in_v[i];
      bus1.in_data[i]  = in_v[i];
    end
    for (int i = 0; i < 3; i++) bus2.in_data[i] = in_v[i];
    bus0.sel_data = sel_v;        bus1.sel_data = sel_v;        bus2.sel_data = sel_v;
    bus0.out_down_stop = ods_v;   bus1.out_down_stop = ods_v;   bus2.out_down_stop = ods_v;
    bus0.chose_down_stop = cds_v; bus1.chose_down_stop = cds_v; bus2.chose_down_stop = cds_v;
    #4;
    model_eval();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) in_v[i] = 9'b0_xxxx_xxxx;
    sel_v = 3'b000;
  endtask

  // Monitor: pops the scoreboard whenever a DUT transfers its entry downstream.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #4;
      if (armed && rst === 1'b0) begin
        for (int d = 0; d < 3; d++) begin
          check($sformatf("valid_pair[dut%0d]", d), 32'(cd[d][2]), 32'(od[d][8]));
          if (od[d][8] === 1'b1 && a_ods === 1'b0 && a_cds === 1'b0) begin
            check($sformatf("sb_has_token[dut%0d]", d), 32'(exp_q[d].size() != 0), 32'd1);
            if (exp_q[d].size() != 0) begin
              e = exp_q[d].pop_front();
              check($sformatf("out_payload[dut%0d]", d), 32'(od[d][7:0]), 32'(e.payload));
              check($sformatf("chose_idx[dut%0d]", d), 32'(cd[d][1:0]), 32'(e.idx));
            end
          end
        end
      end
    end
  end

  initial begin
    rst_v = 1'b1;
    ods_v = 1'b0;
    cds_v = 1'b0;
    idle_inputs();
    repeat (3) tick();
    rst_v = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) check($sformatf("reset_out_valid[dut%0d]", d), 32'(od[d][8]), 32'd0);

    // Steered grant of channel 2
    idle_inputs();
    in_v[2] = 9'h1A5;
    sel_v   = 3'b110;
    tick();
    check("steer_in_back_stop", 32'(ibs[0]), 32'b1011);
    check("steer_sel_back_stop", 32'(sbs[0]), 32'd0);
    idle_inputs();
    tick();
    check("steer_out_data", 32'(od[0]), 32'h1A5);
    check("steer_chose_data", 32'(cd[0]), 32'b110);

    // Select points at an invalid channel while another is valid
    idle_inputs();
    in_v[0] = 9'h111;
    sel_v   = 3'b101;
    tick();
    check("nofire_in_back_stop", 32'(ibs[0]), 32'hF);
    check("nofire_sel_back_stop", 32'(sbs[0]), 32'd1);
    tick();
    check("nofire_out_valid", 32'(od[0][8]), 32'd0);

    // Held entry under chose stall, then drain and refill in the same cycle
    idle_inputs();
    in_v[0] = 9'h133;
    sel_v   = 3'b100;
    cds_v   = 1'b1;
    tick();
    check("stall_fire_in_back_stop", 32'(ibs[0]), 32'b1110);
    idle_inputs();
    in_v[3] = 9'h144;
    sel_v   = 3'b111;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_in_back_stop", 32'(ibs[0]), 32'hF);
      check("stall_sel_back_stop", 32'(sbs[0]), 32'd1);
      check("stall_out_data", 32'(od[0]), 32'h133);
      check("stall_chose_data", 32'(cd[0]), 32'b100);
    end
    cds_v = 1'b0;
    tick();
    check("refill_in_back_stop", 32'(ibs[0]), 32'b0111);
    check("refill_sel_back_stop", 32'(sbs[0]), 32'd0);
    idle_inputs();
    tick();
    check("refill_out_data", 32'(od[0]), 32'h144);
    check("refill_chose_data", 32'(cd[0]), 32'b111);

    // Out-of-range select on the three-channel instance
    tick();
    sel_v = 3'b111;
    tick();
    check("badsel_sel_back_stop", 32'(sbs[2]), 32'd0);
    idle_inputs();
    tick();
    check("badsel_err_pulse", 32'(err[2]), 32'd1);
    check("badsel_out_valid", 32'(od[2][8]), 32'd0);
    tick();
    check("badsel_err_cleared", 32'(err[2]), 32'd0);

    // Stall a round-robin entry, reset mid-stream, then stream from channel 0
    for (int i = 0; i < 4; i++) in_v[i] = 9'h150 + 9'(i);
    cds_v = 1'b1;
    repeat (2) tick();
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
    cds_v = 1'b0;
    tick();
    check("rst_mid_out_valid", 32'(od[1][8]), 32'd0);
    check("rst_mid_chose_valid", 32'(cd[1][2]), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("rr_seq_%0d", k), 32'(cd[1]), 32'({1'b1, 2'((k - 1) % 4)}));
    end

    // Randomised traffic with occasional stalls and resets
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 4; i++)
        in_v[i] = ($urandom_range(0, 9) < 6) ? {1'b1, 8'($urandom)} : 9'b0_xxxx_xxxx;
      sel_v = {($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3))};
      ods_v = ($urandom_range(0, 9) < 3);
      cds_v = ($urandom_range(0, 9) < 3);
      rst_v = ($urandom_range(0, 199) == 0);
      tick();
    end

    // Drain everything and confirm no expected token was left behind
    rst_v = 1'b0;
    ods_v = 1'b0;
    cds_v = 1'b0;
    idle_inputs();
    repeat (4) tick();
    #2;
    for (int d = 0; d < 3; d++) check($sformatf("sb_drained[dut%0d]", d), 32'(exp_q[d].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
